nway_cache: RTL

Parametrised N-way set-associative, write-back, write-allocate cache with an integrated controller FSM and per-set tree pseudo-LRU replacement. It sits between the LC-3b CPU memory port (16-bit words) and physical memory (128-bit lines) and replaces the fixed 4-way datapath/control pair. Compared with that pair, it adds:
- A generalised way count and set count.
- Asynchronous clearing of valid, dirty and PLRU state.
- Saturating hit and miss counters.

---
 rtl/nway_cache.sv | 308 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/nway_cache.sv
// nway_cache
// ----------
// N-way set-associative, write-back, write-allocate cache between the LC-3b
// CPU memory port (16-bit words) and physical memory (128-bit lines), with
// an integrated controller FSM and per-set tree pseudo-LRU replacement.
//
// Ports
//   clk, reset           : clock; asynchronous active-high reset
//   mem_read/mem_write   : CPU request, held until mem_resp
//   mem_address          : byte address (tag | index | word | byte)
//   mem_wdata, mem_byte_enable : write data and byte lanes
//   mem_rdata, mem_resp  : read data of the hit way, completion strobe
//   pmem_read/pmem_write : line fill / writeback request, held until pmem_resp
//   pmem_address         : line-aligned physical address
//   pmem_wdata/pmem_rdata: victim line out / fill line in
//   pmem_resp            : physical memory completion strobe
//   hit_count/miss_count : saturating event counters
module nway_cache #(
    parameter int WAYS = 4,
    parameter int SETS = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [15:0]  mem_address,
    input  logic [15:0]  mem_wdata,
    input  logic [1:0]   mem_byte_enable,
    output logic [15:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [15:0]  pmem_address,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp,
    output logic [15:0]  hit_count,
    output logic [15:0]  miss_count
);

    localparam int IDX   = $clog2(SETS);
    localparam int TAG   = 12 - IDX;
    localparam int WW    = $clog2(WAYS);
    localparam int NODES = WAYS - 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WB   = 2'd1,
        ST_FILL = 2'd2
    } state_t;

    // Walk the PLRU tree from the root; each node bit selects the half
    // that holds the victim (0 = lower-index half).
    function automatic logic [WW-1:0] plru_victim(input logic [NODES-1:0] bits);
        logic [WW-1:0] v;
        int            n;
        v = '0;
        n = 0;
        for (int l = 0; l < WW; l++) begin
            v[WW-1-l] = bits[n];
            n = 2 * n + 1 + int'(bits[n]);
        end
        return v;
    endfunction

    // Make every node on the path to 'way' point away from it.
    function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                    input logic [WW-1:0]    way);
        logic [NODES-1:0] r;
        int               n;
        r = bits;
        n = 0;
        for (int l = 0; l < WW; l++) begin
            r[n] = ~way[WW-1-l];
            n = 2 * n + 1 + int'(way[WW-1-l]);
        end
        return r;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : (c + 16'd1);
    endfunction

    // Storage: tag/data arrays are not reset; valid/dirty/PLRU are flat
    // vectors (way-major for valid/dirty, set-major for PLRU).
    logic [TAG-1:0]       tag_arr_q  [WAYS][SETS];
    logic [127:0]         data_arr_q [WAYS][SETS];
    logic [WAYS*SETS-1:0] valid_q, valid_d;
    logic [WAYS*SETS-1:0] dirty_q, dirty_d;
    logic [SETS*NODES-1:0] plru_q, plru_d;

    state_t         state_q, state_d;
    logic [WW-1:0]  victim_q, victim_d;
    logic [TAG-1:0] tag_q, tag_d;
    logic [IDX-1:0] idx_q, idx_d;
    logic           fill_done_q, fill_done_d;
    logic [15:0]    hit_cnt_q, hit_cnt_d;
    logic [15:0]    miss_cnt_q, miss_cnt_d;

    logic [TAG-1:0]   req_tag_s;
    logic [IDX-1:0]   req_idx_s;
    logic [2:0]       word_s;
    logic             req_s;
    logic             hit_s;
    logic [WW-1:0]    hit_way_s;
    logic [WW-1:0]    victim_s;
    logic             inv_found_s;
    logic [NODES-1:0] cur_plru_s;
    logic [127:0]     hit_line_s;
    logic [15:0]      old_word_s;
    logic [15:0]      new_word_s;
    logic [127:0]     merged_line_s;

    logic             data_we_s;
    logic [WW-1:0]    data_wway_s;
    logic [IDX-1:0]   data_widx_s;
    logic [127:0]     data_wline_s;
    logic             tag_we_s;

    logic             unused_addr_s;

    assign req_tag_s     = mem_address[15:4+IDX];
    assign req_idx_s     = mem_address[3+IDX:4];
    assign word_s        = mem_address[3:1];
    assign req_s         = mem_read | mem_write;
    assign unused_addr_s = mem_address[0];
    assign cur_plru_s    = plru_q[int'(req_idx_s)*NODES +: NODES];

    // Hit detection and victim choice for the set addressed by the CPU.
    always_comb begin
        hit_s       = 1'b0;
        hit_way_s   = '0;
        victim_s    = '0;
        inv_found_s = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w*SETS + int'(req_idx_s)] && (tag_arr_q[w][req_idx_s] == req_tag_s)) begin
                hit_s     = 1'b1;
                hit_way_s = WW'(w);
            end else begin
                hit_s = hit_s;
            end
        end
        // Descending scan so the lowest-index invalid way wins.
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w*SETS + int'(req_idx_s)]) begin
                victim_s    = WW'(w);
                inv_found_s = 1'b1;
            end else begin
                inv_found_s = inv_found_s;
            end
        end
        if (!inv_found_s) begin
            victim_s = plru_victim(cur_plru_s);
        end else begin
            victim_s = victim_s;
        end
    end

    // Read path of the hit way and the byte-merged line for write hits.
    always_comb begin
        hit_line_s    = data_arr_q[hit_way_s][req_idx_s];
        old_word_s    = hit_line_s[{word_s, 4'b0000} +: 16];
        new_word_s    = {mem_byte_enable[1] ? mem_wdata[15:8] : old_word_s[15:8],
                         mem_byte_enable[0] ? mem_wdata[7:0]  : old_word_s[7:0]};
        merged_line_s = hit_line_s;
        merged_line_s[{word_s, 4'b0000} +: 16] = new_word_s;
    end

    // Controller: next state, array write controls and counters.
    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        tag_d        = tag_q;
        idx_d        = idx_q;
        fill_done_d  = fill_done_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        valid_d      = valid_q;
        dirty_d      = dirty_q;
        plru_d       = plru_q;
        mem_resp     = 1'b0;
        data_we_s    = 1'b0;
        data_wway_s  = '0;
        data_widx_s  = '0;
        data_wline_s = '0;
        tag_we_s     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Only the cycle right after a fill is the refill completion.
                fill_done_d = 1'b0;
                if (req_s && hit_s) begin
                    mem_resp = 1'b1;
                    plru_d[int'(req_idx_s)*NODES +: NODES] = plru_touch(cur_plru_s, hit_way_s);
                    if (!fill_done_q) begin
                        hit_cnt_d = sat_inc(hit_cnt_q);
                    end else begin
                        hit_cnt_d = hit_cnt_q;
                    end
                    if (mem_write) begin
                        data_we_s    = 1'b1;
                        data_wway_s  = hit_way_s;
                        data_widx_s  = req_idx_s;
                        data_wline_s = merged_line_s;
                        dirty_d[int'(hit_way_s)*SETS + int'(req_idx_s)] = 1'b1;
                    end else begin
                        data_we_s = 1'b0;
                    end
                end else if (req_s) begin
                    victim_d   = victim_s;
                    tag_d      = req_tag_s;
                    idx_d      = req_idx_s;
                    miss_cnt_d = sat_inc(miss_cnt_q);
                    if (valid_q[int'(victim_s)*SETS + int'(req_idx_s)] &&
                        dirty_q[int'(victim_s)*SETS + int'(req_idx_s)]) begin
                        state_d = ST_WB;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WB: begin
                if (pmem_resp) begin
                    state_d = ST_FILL;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_FILL: begin
                if (pmem_resp) begin
                    data_we_s    = 1'b1;
                    data_wway_s  = victim_q;
                    data_widx_s  = idx_q;
                    data_wline_s = pmem_rdata;
                    tag_we_s     = 1'b1;
                    valid_d[int'(victim_q)*SETS + int'(idx_q)] = 1'b1;
                    dirty_d[int'(victim_q)*SETS + int'(idx_q)] = 1'b0;
                    plru_d[int'(idx_q)*NODES +: NODES] =
                        plru_touch(plru_q[int'(idx_q)*NODES +: NODES], victim_q);
                    fill_done_d = 1'b1;
                    state_d     = ST_IDLE;
                end else begin
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Physical memory side is decoded straight from the state register so
    // an asynchronous reset drops the requests immediately.
    always_comb begin
        pmem_read  = (state_q == ST_FILL);
        pmem_write = (state_q == ST_WB);
        pmem_wdata = data_arr_q[victim_q][idx_q];
        if (state_q == ST_FILL) begin
            pmem_address = {tag_q, idx_q, 4'h0};
        end else begin
            pmem_address = {tag_arr_q[victim_q][idx_q], idx_q, 4'h0};
        end
    end

    assign mem_rdata  = hit_line_s[{word_s, 4'b0000} +: 16];
    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;

    // Control and bookkeeping state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            victim_q    <= '0;
            tag_q       <= '0;
            idx_q       <= '0;
            fill_done_q <= 1'b0;
            hit_cnt_q   <= 16'h0000;
            miss_cnt_q  <= 16'h0000;
            valid_q     <= '0;
            dirty_q     <= '0;
            plru_q      <= '0;
        end else begin
            state_q     <= state_d;
            victim_q    <= victim_d;
            tag_q       <= tag_d;
            idx_q       <= idx_d;
            fill_done_q <= fill_done_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            plru_q      <= plru_d;
        end
    end

    // Tag and data arrays: synchronous write, never written while in reset.
    always_ff @(posedge clk) begin
        if (data_we_s && !reset) begin
            data_arr_q[data_wway_s][data_widx_s] <= data_wline_s;
        end
        if (tag_we_s && !reset) begin
            tag_arr_q[victim_q][idx_q] <= tag_q;
        end
    end

endmodule
